icache_controller: RTL and testbench

Direct-mapped, read-only instruction cache between the program counter and main memory in the RISC-V core. It looks up the fetch address each cycle and returns the instruction on a hit. On a miss it raises `Stall`, which freezes the program counter, and refills the 4-word block from memory with a word-serial handshake. When the refill completes it releases `Stall`.

---
 rtl/icache_controller_if.sv | 33 +++
 rtl/icache_controller.sv | 129 ++++++++++++
 tb/tb_icache_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_controller_if.sv
// Fetch and refill bus of the instruction cache.
// slave: the cache itself. master: the program counter and main memory side.
interface icache_controller_if #(
    parameter int width = 32
);
    logic [width-1:0] PC;
    logic [width-1:0] Instr;
    logic             Stall;
    logic             MemReq;
    logic [width-1:0] MemAddr;
    logic [width-1:0] MemData;
    logic             MemValid;

    modport slave (
        input  PC,
        input  MemData,
        input  MemValid,
        output Instr,
        output Stall,
        output MemReq,
        output MemAddr
    );

    modport master (
        output PC,
        output MemData,
        output MemValid,
        input  Instr,
        input  Stall,
        input  MemReq,
        input  MemAddr
    );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache.
// A hit returns the instruction combinationally in the same cycle.
// A miss holds Stall high and refills the whole 4-word block from memory,
// one word per MemValid beat.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | look up PC every cycle; a miss latches tag/index
//   REFILL | request beats {miss_tag, miss_index, cnt} until the 4th beat
//   DONE   | one settling cycle so the new line is looked up from IDLE
module icache_controller #(
    parameter int width = 32,
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    icache_controller_if.slave bus
);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = width - 4 - INDEX_W;
    localparam logic [width-1:0] NOP = width'(32'h00000013);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]         cnt;
    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [LINES-1:0]   valid;

    // Tag and data arrays are only trusted once valid is set, so they carry no reset.
    logic [TAG_W-1:0]   tag_array  [LINES];
    logic [width-1:0]   data_array [LINES][WORDS];

    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] pc_index;
    logic [1:0]         pc_word;
    logic               pc_byte_unused;

    logic               hit;
    logic               beat;
    logic               last_beat;
    logic               mem_req;
    logic [width-1:0]   mem_addr;

    assign pc_tag         = bus.PC[width-1:4+INDEX_W];
    assign pc_index       = bus.PC[3+INDEX_W:4];
    assign pc_word        = bus.PC[3:2];
    assign pc_byte_unused = ^bus.PC[1:0];

    // Only IDLE may report a hit; REFILL and DONE always stall.
    assign hit       = (state == IDLE) && valid[pc_index] && (tag_array[pc_index] == pc_tag);
    // MemValid counts only while the request is actually on the bus.
    assign beat      = (state == REFILL) && bus.MemValid;
    assign last_beat = beat && (cnt == 2'd3);

    assign bus.Instr   = hit ? data_array[pc_index][pc_word] : NOP;
    assign bus.Stall   = !hit;
    assign bus.MemReq  = mem_req;
    assign bus.MemAddr = mem_addr;

    // Next-state and refill request decode.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_index, cnt, 2'b00};
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, beat counter, miss latch and line valid bits; reset aborts any refill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            miss_tag   <= '0;
            miss_index <= '0;
            valid      <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && !hit) begin
                miss_tag   <= pc_tag;
                miss_index <= pc_index;
                cnt        <= '0;
            end
            if (beat) begin
                cnt <= cnt + 2'd1;
            end
            if (last_beat) begin
                valid[miss_index] <= 1'b1;
            end
        end
    end

    // Refill writes: each beat lands in its word slot, the tag goes in with the final beat.
    always_ff @(posedge CLK) begin
        if (beat) begin
            data_array[miss_index][cnt] <= bus.MemData;
        end
        if (last_beat) begin
            tag_array[miss_index] <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: stimulus pushes expected refill
// addresses, stall lengths and delivered instructions; a negedge monitor pops
// and compares them whenever the cache presents them.
module tb_icache_controller;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    icache_controller_if #(.width(32)) bus ();

    icache_controller #(.width(32), .LINES(32), .WORDS(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] NOP = 32'h00000013;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q  [$];
    logic [31:0] exp_instr_q [$];
    logic [31:0] exp_stall_q [$];
    int          stall_run = 0;

    // Main memory contents: block 0 holds the hand-picked words, elsewhere a tagged pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return 32'hC0DE0000 ^ a;
        endcase
    endfunction

    assign bus.MemData = mem_word(bus.MemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push_refill(input logic [31:0] base, input logic [31:0] stall_len,
                               input logic [31:0] instr);
        for (int b = 0; b < 4; b++) begin
            exp_addr_q.push_back(base + 32'(4 * b));
        end
        exp_stall_q.push_back(stall_len);
        exp_instr_q.push_back(instr);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.MemReq && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!bus.MemReq) note_fail("req_timeout", "MemReq still 0, required 1");
    endtask

    // Memory side: after the request appears, deliver 4 beats with `gap` idle cycles before each.
    task automatic serve_refill(input int gap);
        wait_req();
        for (int b = 0; b < 4; b++) begin
            repeat (gap) begin
                @(posedge CLK);
                #1;
            end
            bus.MemValid = 1'b1;
            @(posedge CLK);
            #1;
            bus.MemValid = 1'b0;
        end
    endtask

    task automatic wait_nostall();
        int n = 0;
        while (bus.Stall && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (bus.Stall) note_fail("stall_timeout", "Stall still 1, required 0");
    endtask

    // Monitor: compares every presented refill address, stall run and delivered instruction.
    always @(negedge CLK) begin
        if (RST) begin
            stall_run = 0;
        end else begin
            if (bus.Stall) begin
                check("instr_nop_on_stall", bus.Instr, NOP);
                stall_run++;
            end else begin
                if (stall_run > 0) begin
                    if (exp_stall_q.size() == 0)
                        check("stall_unexpected", 32'(stall_run), 32'd0);
                    else
                        check("stall_cycles", 32'(stall_run), exp_stall_q.pop_front());
                    stall_run = 0;
                end
                if (exp_instr_q.size() > 0)
                    check("instr", bus.Instr, exp_instr_q.pop_front());
            end
            if (bus.MemReq) begin
                if (exp_addr_q.size() == 0) begin
                    check("req_unexpected", bus.MemAddr, 32'hFFFFFFFF);
                end else begin
                    check("mem_addr", bus.MemAddr, exp_addr_q[0]);
                    if (bus.MemValid) void'(exp_addr_q.pop_front());
                end
            end else begin
                check("mem_addr_idle", bus.MemAddr, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hit_pc  [3];
        logic [31:0] hit_exp [3];
        logic [31:0] cf_pc   [3];
        logic [31:0] cf_exp  [3];
        hit_pc  = '{32'h4, 32'h8, 32'hC};
        hit_exp = '{32'h22, 32'h33, 32'h44};
        cf_pc   = '{32'h000, 32'h200, 32'h000};
        cf_exp  = '{32'h11, 32'hC0DE0200, 32'h11};

        bus.PC       = 32'h0;
        bus.MemValid = 1'b0;

        // Reset state: all lines invalid, so stall with NOP and no request.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_stall",   {31'b0, bus.Stall},  32'h1);
        check("rst_instr",   bus.Instr,           NOP);
        check("rst_memreq",  {31'b0, bus.MemReq}, 32'h0);
        check("rst_memaddr", bus.MemAddr,         32'h0);

        // Cold miss at PC=0 with back-to-back beats: 6 stall cycles, then 0x11.
        push_refill(32'h0, 32'd6, 32'h11);
        RST = 1'b0;
        serve_refill(0);
        wait_nostall();

        // Hits on the rest of the block, one per cycle.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            bus.PC = hit_pc[i];
            exp_instr_q.push_back(hit_exp[i]);
        end

        // Gapped beats (one every third cycle): stall = 1 + 12 + 1, word 2 delivered.
        @(posedge CLK);
        #1;
        bus.PC = 32'h208;
        push_refill(32'h200, 32'd14, 32'hC0DE0208);
        serve_refill(2);
        wait_nostall();

        // Thrash at index 0: each address refills and returns its own data.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            bus.PC = cf_pc[i];
            push_refill(cf_pc[i], 32'd6, cf_exp[i]);
            serve_refill(0);
            wait_nostall();
        end

        // Reset after beat 1 of a refill of 0x40, then a full refill restarts.
        @(posedge CLK);
        #1;
        bus.PC = 32'h40;
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h44);
        wait_req();
        bus.MemValid = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        bus.MemValid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("abort_memreq",  {31'b0, bus.MemReq}, 32'h0);
        check("abort_memaddr", bus.MemAddr,         32'h0);
        check("abort_stall",   {31'b0, bus.Stall},  32'h1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        push_refill(32'h40, 32'd6, 32'hC0DE0040);
        RST = 1'b0;
        serve_refill(0);
        wait_nostall();

        // Early MemValid in the miss cycle is ignored; PC moves during REFILL.
        @(posedge CLK);
        #1;
        bus.PC       = 32'h80;
        bus.MemValid = 1'b1;
        push_refill(32'h80, 32'd10, 32'hC0DE0080);
        @(posedge CLK);
        #1;
        bus.MemValid = 1'b0;
        bus.PC       = 32'h3F0;
        serve_refill(1);
        bus.PC = 32'h80;
        wait_nostall();

        repeat (3) @(posedge CLK);
        #1;
        check("addr_q_drained",  32'(exp_addr_q.size()),  32'd0);
        check("stall_q_drained", 32'(exp_stall_q.size()), 32'd0);
        check("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
